fwd_bypass_unit: RTL and testbench
==================================

// Module: fwd_bypass_unit
// PURPOSE
//  Parametrised operand bypass network with built-in hazard tracking for the pipelined core.
//  Keeps a shift register of destination tags for in-flight instructions (EX..WB).
//  Per ID-stage read port, picks the regfile value or the youngest ready stage result.
//  Raises a load-use stall; counts stall cycles for performance monitoring.
// PARAMETERS
//  DATA_W       32  operand width
//  REG_AW        5  register address width; register 0 is hard-wired zero
//  NUM_RP        2  number of ID read ports
//  DEPTH         3  tracked stages; index 0 = EX, DEPTH-1 = WB
//  LOAD_RDY      1  first stage index at which load data is forwardable
//  CNT_W        16  stall counter width
// PORTS
//  clk_i          in   1             clock
//  rst_i          in   1             reset, asynchronous, active-high
//  flush_i        in   1             kill the ID instruction this cycle
//  perf_clr_i     in   1             clear stall counter
//  id_valid_i     in   1             ID holds a valid instruction
//  id_we_i        in   1             ID instruction writes a register
//  id_load_i      in   1             ID instruction is a load
//  id_rd_i        in   REG_AW        ID destination register
//  id_rs_i        in   NUM_RP*REG_AW source register per port, port p at [p*REG_AW +: REG_AW]
//  reg_data_i     in   NUM_RP*DATA_W regfile read data per port
//  stage_data_i   in   DEPTH*DATA_W  result of stage k at [k*DATA_W +: DATA_W]
//  data_o         out  NUM_RP*DATA_W forwarded operand per port
//  sel_o          out  NUM_RP*SEL_W  chosen source per port; SEL_W = clog2(DEPTH+1)
//  stall_o        out  1             hold IF/ID, insert bubble into EX
//  stall_cnt_o    out  CNT_W         saturating count of stall cycles
// BEHAVIOUR
//  Tag entry k = {v, we, ld, rd}. Reset (async): all entries v=0; stall_cnt_o=0.
//  During reset: stall_o=0, sel_o=0, data_o=reg_data_i.
//  Each posedge, entries 1..DEPTH-1 take entry k-1; the oldest entry is dropped.
//  Entry 0 loads {id_valid_i, id_we_i, id_load_i, id_rd_i} only if !stall_o && !flush_i.
//  Otherwise entry 0 gets a bubble (v=0). Older entries always advance; no freeze.
//  Per port p, combinational, zero latency:
//   - rs==0: sel=0, data=reg_data.
//   - Otherwise scan k=0..DEPTH-1; first hit (v&we&rd==rs) wins, so the youngest producer wins.
//   - Hit is ready unless (ld && k<LOAD_RDY). Ready: sel=k+1, data=stage_data[k].
//   - Hit not ready: port hazard; data_o is don't-care (drive reg_data).
//   - No hit: sel=0, data=reg_data.
//  A not-ready hit blocks older matches; never fall through to a stale value.
//  stall_o = id_valid_i & !flush_i & (OR of port hazards).
//  Load-use gap with LOAD_RDY=1 is 1 cycle; with general LOAD_RDY it is LOAD_RDY cycles.
//  Counter: perf_clr_i -> 0 (clear wins over increment).
//   Else if stall_o and not all-ones -> +1. Saturates at 2^CNT_W-1.
//  flush_i together with a hazard: no stall; the bubble still enters EX.
//  Ports are independent. Both ports may hit different stages the same cycle.
// STRUCTURE
//  Shared constants file:
//   - FWD_SEL_REG=0; stage k encoding = k+1.
//   - Tag-entry field widths/offsets.
//   - Existing Reg_src/EX_src/MEM_src values must equal sel 0/1/2.
//  Sub-module fwd_port_sel (pure combinational priority scan, one port):
//   - One instance per port via generate.
//  Top holds the tag shift register, stall gating and counter.
// TESTING
//  1. Issue rd=5 we=1; next cycle rs0=5, stage_data[0]=0xAAAA0001 -> sel0=1, data0=0xAAAA0001, stall_o=0.
//  2. Load rd=6; next cycle rs1=6 -> stall_o=1 one cycle, EX bubble.
//     Next cycle: sel1=2, data1=stage_data[1]. stall_cnt_o=1.
//  3. Producer rd=0 we=1; consumer rs0=0 -> sel0=0, data0=reg_data_i; never stalls.
//  4. Two producers of x7 in EX and MEM; rs0=7 -> sel0=1 (EX value).
//     Repeat with the EX producer a load -> stall_o=1, not sel 2.
//  5. CNT_W=4, hold a hazard 20 cycles -> stall_cnt_o=15.
//     perf_clr_i with stall_o=1 -> 0. flush_i with hazard -> stall_o=0.
//  6. Assert rst_i mid-sequence between clock edges -> immediately stall_o=0, sel=0, stall_cnt_o=0.
//     After release, a dependent pair forwards correctly.

Source files
------------

// File: rtl/fwd_bypass_unit_pkg.sv
// rtl/fwd_bypass_unit_pkg.sv - shared select encodings and tag-entry layout for the bypass network
package fwd_bypass_unit_pkg;

  // Operand source select: 0 is the regfile, tracked stage k is encoded as k+1.
  localparam int FWD_SEL_REG = 0;

  typedef enum logic [1:0] {
    Reg_src = 2'(FWD_SEL_REG),
    EX_src  = 2'd1,
    MEM_src = 2'd2
  } fwd_src_e;

  // Tag entry {v, we, ld, rd}: rd occupies the low bits and the flags sit above it.
  localparam int TAG_RD_LSB = 0;
  localparam int TAG_FLAGS  = 3;

  function automatic int tag_w(input int reg_aw);
    return reg_aw + TAG_FLAGS;
  endfunction

  function automatic int tag_ld_bit(input int reg_aw);
    return reg_aw;
  endfunction

  function automatic int tag_we_bit(input int reg_aw);
    return reg_aw + 1;
  endfunction

  function automatic int tag_v_bit(input int reg_aw);
    return reg_aw + 2;
  endfunction

  function automatic int stage_sel(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// rtl/fwd_port_sel.sv - priority scan of tracked stages for one ID read port
module fwd_port_sel
  import fwd_bypass_unit_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_RDY = 1,
  parameter int SEL_W    = 2,
  localparam int TAG_W   = tag_w(REG_AW)
) (
  input  logic [REG_AW-1:0]       rs,
  input  logic [DATA_W-1:0]       reg_data,
  input  logic [DEPTH*DATA_W-1:0] stage_data,
  input  logic [DEPTH*TAG_W-1:0]  tags,
  output logic [DATA_W-1:0]       data,
  output logic [SEL_W-1:0]        sel,
  output logic                    hazard
);

  localparam int V_BIT  = tag_v_bit(REG_AW);
  localparam int WE_BIT = tag_we_bit(REG_AW);
  localparam int LD_BIT = tag_ld_bit(REG_AW);

  logic [TAG_W-1:0] entry;
  logic             found;

  // The first matching entry is the youngest producer; once found, older
  // matches are ignored even when that producer cannot forward yet.
  always_comb begin
    data   = reg_data;
    sel    = SEL_W'(FWD_SEL_REG);
    hazard = 1'b0;
    found  = 1'b0;
    entry  = '0;
    if (rs != '0) begin
      for (int k = 0; k < DEPTH; k++) begin
        entry = tags[k*TAG_W +: TAG_W];
        if (!found && entry[V_BIT] && entry[WE_BIT] &&
            entry[TAG_RD_LSB +: REG_AW] == rs) begin
          found = 1'b1;
          if (entry[LD_BIT] && k < LOAD_RDY) begin
            hazard = 1'b1;
          end else begin
            sel  = SEL_W'(stage_sel(k));
            data = stage_data[k*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

endmodule

// File: rtl/fwd_bypass_unit.sv
// rtl/fwd_bypass_unit.sv - operand bypass network with in-flight tag tracking and load-use stall
module fwd_bypass_unit
  import fwd_bypass_unit_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_RP   = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_RDY = 1,
  parameter int CNT_W    = 16,
  localparam int SEL_W   = $clog2(DEPTH + 1),
  localparam int TAG_W   = tag_w(REG_AW)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     perf_clr_i,
  input  logic                     id_valid_i,
  input  logic                     id_we_i,
  input  logic                     id_load_i,
  input  logic [REG_AW-1:0]        id_rd_i,
  input  logic [NUM_RP*REG_AW-1:0] id_rs_i,
  input  logic [NUM_RP*DATA_W-1:0] reg_data_i,
  input  logic [DEPTH*DATA_W-1:0]  stage_data_i,
  output logic [NUM_RP*DATA_W-1:0] data_o,
  output logic [NUM_RP*SEL_W-1:0]  sel_o,
  output logic                     stall_o,
  output logic [CNT_W-1:0]         stall_cnt_o
);

  logic [TAG_W-1:0]       tag_q [DEPTH];
  logic [DEPTH*TAG_W-1:0] tags_flat;
  logic [TAG_W-1:0]       id_tag;
  logic [NUM_RP-1:0]      port_hazard;
  logic [CNT_W-1:0]       cnt_q;

  assign id_tag = {id_valid_i, id_we_i, id_load_i, id_rd_i};

  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign tags_flat[k*TAG_W +: TAG_W] = tag_q[k];
  end

  // Older entries always advance; EX takes a bubble whenever ID is held or killed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        tag_q[k] <= tag_q[k-1];
      end
      tag_q[0] <= (stall_o || flush_i) ? '0 : id_tag;
    end
  end

  for (genvar p = 0; p < NUM_RP; p++) begin : g_port
    fwd_port_sel #(
      .DATA_W  (DATA_W),
      .REG_AW  (REG_AW),
      .DEPTH   (DEPTH),
      .LOAD_RDY(LOAD_RDY),
      .SEL_W   (SEL_W)
    ) u_sel (
      .rs        (id_rs_i[p*REG_AW +: REG_AW]),
      .reg_data  (reg_data_i[p*DATA_W +: DATA_W]),
      .stage_data(stage_data_i),
      .tags      (tags_flat),
      .data      (data_o[p*DATA_W +: DATA_W]),
      .sel       (sel_o[p*SEL_W +: SEL_W]),
      .hazard    (port_hazard[p])
    );
  end

  assign stall_o = id_valid_i & ~flush_i & (|port_hazard);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (perf_clr_i) begin
      cnt_q <= '0;
    end else if (stall_o && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_bypass_unit.sv
// tb/tb_fwd_bypass_unit.sv - vector table, corner sequences and random model check for fwd_bypass_unit
module tb_fwd_bypass_unit;

  localparam int DEPTH    = 3;
  localparam int LOAD_RDY = 1;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i, perf_clr_i, id_valid_i, id_we_i, id_load_i;
  logic [4:0]  id_rd_i;
  logic [9:0]  id_rs_i;
  logic [63:0] reg_data_i;
  logic [95:0] stage_data_i;
  logic [63:0] data_o, data4;
  logic [3:0]  sel_o, sel4;
  logic        stall_o, stall4;
  logic [15:0] stall_cnt_o;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  fwd_bypass_unit #(.DATA_W(32), .REG_AW(5), .NUM_RP(2), .DEPTH(DEPTH),
                    .LOAD_RDY(LOAD_RDY), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .perf_clr_i(perf_clr_i),
    .id_valid_i(id_valid_i), .id_we_i(id_we_i), .id_load_i(id_load_i),
    .id_rd_i(id_rd_i), .id_rs_i(id_rs_i), .reg_data_i(reg_data_i),
    .stage_data_i(stage_data_i), .data_o(data_o), .sel_o(sel_o),
    .stall_o(stall_o), .stall_cnt_o(stall_cnt_o));

  fwd_bypass_unit #(.DATA_W(32), .REG_AW(5), .NUM_RP(2), .DEPTH(DEPTH),
                    .LOAD_RDY(LOAD_RDY), .CNT_W(4)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .perf_clr_i(perf_clr_i),
    .id_valid_i(id_valid_i), .id_we_i(id_we_i), .id_load_i(id_load_i),
    .id_rd_i(id_rd_i), .id_rs_i(id_rs_i), .reg_data_i(reg_data_i),
    .stage_data_i(stage_data_i), .data_o(data4), .sel_o(sel4),
    .stall_o(stall4), .stall_cnt_o(cnt4));

  always #5 clk_i = ~clk_i;

  // Reference model: list of recently issued instructions, youngest first.
  typedef struct {
    bit         v;
    bit         we;
    bit         ld;
    logic [4:0] rd;
  } instr_t;

  instr_t hist[$];
  int     mcnt  = 0;
  int     mcnt4 = 0;

  function automatic void model_port(input logic [4:0] rs, output int sel, output bit haz);
    sel = 0;
    haz = 1'b0;
    if (rs == 5'd0) return;
    foreach (hist[a]) begin
      if (hist[a].v && hist[a].we && hist[a].rd == rs) begin
        if (hist[a].ld && a < LOAD_RDY) haz = 1'b1;
        else sel = a + 1;
        return;
      end
    end
  endfunction

  function automatic bit model_stall();
    int s0, s1;
    bit h0, h1;
    model_port(id_rs_i[4:0], s0, h0);
    model_port(id_rs_i[9:5], s1, h1);
    return id_valid_i && !flush_i && (h0 || h1);
  endfunction

  function automatic logic [31:0] exp_data(input int p, input int sel);
    if (sel == 0) return reg_data_i[p*32 +: 32];
    return stage_data_i[(sel-1)*32 +: 32];
  endfunction

  task automatic model_update();
    instr_t e;
    bit st;
    st = model_stall();
    if (perf_clr_i) begin
      mcnt  = 0;
      mcnt4 = 0;
    end else if (st) begin
      if (mcnt < 65535) mcnt++;
      if (mcnt4 < 15) mcnt4++;
    end
    e.v  = (st || flush_i) ? 1'b0 : id_valid_i;
    e.we = id_we_i;
    e.ld = id_load_i;
    e.rd = id_rd_i;
    hist.push_front(e);
    if (hist.size() > DEPTH) void'(hist.pop_back());
  endtask

  task automatic model_reset();
    hist.delete();
    mcnt  = 0;
    mcnt4 = 0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int s0, s1;
    bit h0, h1;
    model_port(id_rs_i[4:0], s0, h0);
    model_port(id_rs_i[9:5], s1, h1);
    check($sformatf("%s_stall", tag), 64'(stall_o), 64'(model_stall()));
    check($sformatf("%s_sel0", tag), 64'(sel_o[1:0]), 64'(s0));
    check($sformatf("%s_sel1", tag), 64'(sel_o[3:2]), 64'(s1));
    check($sformatf("%s_data0", tag), 64'(data_o[31:0]), 64'(exp_data(0, s0)));
    check($sformatf("%s_data1", tag), 64'(data_o[63:32]), 64'(exp_data(1, s1)));
    check($sformatf("%s_cnt", tag), 64'(stall_cnt_o), 64'(mcnt));
    check($sformatf("%s_cnt4", tag), 64'(cnt4), 64'(mcnt4));
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic ld, input logic [4:0] rd,
                       input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic fl, input logic clr);
    id_valid_i = v;
    id_we_i    = we;
    id_load_i  = ld;
    id_rd_i    = rd;
    id_rs_i    = {rs1, rs0};
    flush_i    = fl;
    perf_clr_i = clr;
  endtask

  typedef struct {
    logic       v, we, ld;
    logic [4:0] rd, rs0, rs1;
    logic       fl, clr;
    logic       stall;
    logic [1:0] sel0, sel1;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic we, input logic ld, input logic [4:0] rd,
                              input logic [4:0] rs0, input logic [4:0] rs1, input logic fl,
                              input logic clr, input logic stall, input logic [1:0] sel0,
                              input logic [1:0] sel1, input logic [15:0] cnt);
    vec_t r;
    r.v = v; r.we = we; r.ld = ld; r.rd = rd; r.rs0 = rs0; r.rs1 = rs1;
    r.fl = fl; r.clr = clr; r.stall = stall; r.sel0 = sel0; r.sel1 = sel1; r.cnt = cnt;
    return r;
  endfunction

  vec_t tbl[19];

  initial begin
    //          v  we ld rd  rs0 rs1 fl clr | stall sel0 sel1 cnt
    tbl[0]  = mk(1, 1, 0, 5,  0,  0, 0, 0,   0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0,  5,  0, 0, 0,   0, 1, 0, 0);
    tbl[2]  = mk(1, 1, 1, 6,  0,  0, 0, 0,   0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0,  0,  6, 0, 0,   1, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0,  0,  6, 0, 0,   0, 0, 2, 1);
    tbl[5]  = mk(1, 1, 1, 0,  0,  0, 0, 0,   0, 0, 0, 1);
    tbl[6]  = mk(1, 0, 0, 0,  0,  0, 0, 0,   0, 0, 0, 1);
    tbl[7]  = mk(1, 1, 0, 7,  0,  0, 0, 0,   0, 0, 0, 1);
    tbl[8]  = mk(1, 1, 0, 7,  0,  0, 0, 0,   0, 0, 0, 1);
    tbl[9]  = mk(1, 0, 0, 0,  7,  7, 0, 0,   0, 1, 1, 1);
    tbl[10] = mk(1, 1, 1, 7,  0,  0, 0, 0,   0, 0, 0, 1);
    tbl[11] = mk(1, 0, 0, 0,  7,  0, 0, 0,   1, 0, 0, 1);
    tbl[12] = mk(1, 0, 0, 0,  7,  0, 0, 0,   0, 2, 0, 2);
    tbl[13] = mk(1, 1, 1, 9,  0,  0, 0, 0,   0, 0, 0, 2);
    tbl[14] = mk(1, 0, 0, 0,  9,  0, 1, 0,   0, 0, 0, 2);
    tbl[15] = mk(1, 0, 0, 0,  9,  0, 0, 0,   0, 2, 0, 2);
    tbl[16] = mk(1, 1, 1, 10, 0,  0, 0, 0,   0, 0, 0, 2);
    tbl[17] = mk(1, 0, 0, 0,  0, 10, 0, 1,   1, 0, 0, 2);
    tbl[18] = mk(1, 0, 0, 0,  0, 10, 0, 0,   0, 0, 2, 0);

    rst_i        = 1'b1;
    reg_data_i   = {32'h11110011, 32'h00000010};
    stage_data_i = {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
    drive(1, 1, 1, 5'd4, 5'd4, 5'd4, 0, 0);
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_stall", 64'(stall_o), 64'd0);
    check("reset_sel", 64'(sel_o), 64'd0);
    check("reset_data", data_o, reg_data_i);
    check("reset_cnt", 64'(stall_cnt_o), 64'd0);
    rst_i = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].v, tbl[i].we, tbl[i].ld, tbl[i].rd, tbl[i].rs0, tbl[i].rs1,
            tbl[i].fl, tbl[i].clr);
      @(negedge clk_i);
      check($sformatf("vec%0d_stall", i), 64'(stall_o), 64'(tbl[i].stall));
      check($sformatf("vec%0d_sel0", i), 64'(sel_o[1:0]), 64'(tbl[i].sel0));
      check($sformatf("vec%0d_sel1", i), 64'(sel_o[3:2]), 64'(tbl[i].sel1));
      check($sformatf("vec%0d_data0", i), 64'(data_o[31:0]), 64'(exp_data(0, int'(tbl[i].sel0))));
      check($sformatf("vec%0d_data1", i), 64'(data_o[63:32]), 64'(exp_data(1, int'(tbl[i].sel1))));
      check($sformatf("vec%0d_cnt", i), 64'(stall_cnt_o), 64'(tbl[i].cnt));
      check_model($sformatf("vec%0d", i));
      tick();
    end

    // Back-to-back self-dependent loads stall every other cycle: 20 stalls in 40 cycles.
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk_i);
    check_model("satclr");
    tick();
    for (int i = 0; i < 40; i++) begin
      drive(1, 1, 1, 5'd12, 5'd12, 5'd0, 0, 0);
      @(negedge clk_i);
      check_model($sformatf("sat%0d", i));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    check("sat_cnt16", 64'(stall_cnt_o), 64'd20);
    check("sat_cnt4", 64'(cnt4), 64'd15);
    tick();

    // Asynchronous reset between edges while a stall is active.
    drive(1, 1, 1, 5'd13, 0, 0, 0, 0);
    @(negedge clk_i);
    check_model("pre_rst_ld");
    tick();
    drive(1, 0, 0, 0, 5'd13, 0, 0, 0);
    @(negedge clk_i);
    check_model("pre_rst_use");
    #2;
    rst_i = 1'b1;
    model_reset();
    #1;
    check("midrst_stall", 64'(stall_o), 64'd0);
    check("midrst_sel", 64'(sel_o), 64'd0);
    check("midrst_data", data_o, reg_data_i);
    check("midrst_cnt", 64'(stall_cnt_o), 64'd0);
    check("midrst_cnt4", 64'(cnt4), 64'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    drive(1, 1, 0, 5'd3, 0, 0, 0, 0);
    @(negedge clk_i);
    check_model("post_rst_prod");
    tick();
    drive(1, 0, 0, 0, 0, 5'd3, 0, 0);
    @(negedge clk_i);
    check("post_rst_sel1", 64'(sel_o[3:2]), 64'd1);
    check("post_rst_data1", 64'(data_o[63:32]), 64'(stage_data_i[31:0]));
    check("post_rst_stall", 64'(stall_o), 64'd0);
    tick();

    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 1), $urandom_range(0, 9) < 4,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
      reg_data_i   = {$urandom, $urandom};
      stage_data_i = {$urandom, $urandom, $urandom};
      @(negedge clk_i);
      check_model($sformatf("rnd%0d", i));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
